// File: rtl/vram_port_arbiter.sv
// Single-port sprite SPRAM arbiter between the display pixel fetch (reads)
// and the SPI command drain (writes). One access per cycle, registered SPRAM
// controls, fixed two-cycle read return and a starvation guard for writes.
module vram_port_arbiter #(
  parameter int unsigned ADDR_BITS    = 14,
  parameter int unsigned DATA_BITS    = 16,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 display_active_i,
  input  logic                 rd_valid_i,
  input  logic [ADDR_BITS-1:0] rd_addr_i,
  output logic                 rd_ready_o,
  output logic [DATA_BITS-1:0] rd_data_o,
  output logic                 rd_data_valid_o,
  input  logic                 wr_valid_i,
  input  logic [ADDR_BITS-1:0] wr_addr_i,
  input  logic [DATA_BITS-1:0] wr_data_i,
  output logic                 wr_ready_o,
  output logic [ADDR_BITS-1:0] mem_addr_o,
  output logic [DATA_BITS-1:0] mem_wdata_o,
  output logic                 mem_we_o,
  input  logic [DATA_BITS-1:0] mem_rdata_i,
  output logic [7:0]           starve_events_o
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

  logic [CntW-1:0]      wait_cnt_q, wait_cnt_d;
  logic [7:0]           starve_q, starve_d;
  logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_BITS-1:0] mem_wdata_q, mem_wdata_d;
  logic                 mem_we_q, mem_we_d;
  logic [1:0]           rd_pipe_q, rd_pipe_d;

  logic rd_grant, wr_grant, forced;
  logic rd_xfer, wr_xfer;

  // Grant selection: display reads win while scanning unless a write has
  // waited long enough; writes win during blanking. Nothing granted in reset.
  always_comb begin
    rd_grant = 1'b0;
    wr_grant = 1'b0;
    forced   = 1'b0;
    if (!reset_i) begin
      if (!display_active_i) begin
        wr_grant = wr_valid_i;
        rd_grant = rd_valid_i & ~wr_valid_i;
      end else if (wr_valid_i && (wait_cnt_q == CntMax)) begin
        wr_grant = 1'b1;
        forced   = 1'b1;
      end else begin
        rd_grant = rd_valid_i;
        wr_grant = wr_valid_i & ~rd_valid_i;
      end
    end
  end

  assign rd_ready_o = rd_grant;
  assign wr_ready_o = wr_grant;
  assign rd_xfer    = rd_valid_i & rd_grant;
  assign wr_xfer    = wr_valid_i & wr_grant;

  // Next-state for the starvation counter, event counter, SPRAM controls
  // and read-return pipeline.
  always_comb begin
    wait_cnt_d  = wait_cnt_q;
    starve_d    = starve_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    rd_pipe_d   = {rd_pipe_q[0], rd_xfer};

    // Counter tracks consecutive denied cycles of a pending write; saturates
    // at the limit, where the forced grant then clears it.
    if (!wr_valid_i || wr_xfer) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != CntMax) begin
      wait_cnt_d = wait_cnt_q + CntW'(1);
    end

    if (forced) begin
      starve_d = starve_q + 8'd1;
    end

    if (wr_xfer) begin
      mem_addr_d  = wr_addr_i;
      mem_wdata_d = wr_data_i;
      mem_we_d    = 1'b1;
    end else if (rd_xfer) begin
      mem_addr_d = rd_addr_i;
    end
  end

  // State registers with synchronous reset; reset also flushes pending reads.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wait_cnt_q  <= '0;
      starve_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      rd_pipe_q   <= '0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      starve_q    <= starve_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      rd_pipe_q   <= rd_pipe_d;
    end
  end

  assign mem_addr_o      = mem_addr_q;
  assign mem_wdata_o     = mem_wdata_q;
  assign mem_we_o        = mem_we_q;
  assign rd_data_o       = mem_rdata_i;
  assign rd_data_valid_o = rd_pipe_q[1];
  assign starve_events_o = starve_q;

endmodule

// File: doc/vram_port_arbiter.md
# vram_port_arbiter

Shares the single-port sprite SPRAM between two requesters: the display pixel fetch pipeline (reads) and the SPI command drain (writes). Each cycle it grants at most one access, registers the SPRAM address, data and write-enable, and returns read data with fixed latency. Display reads win while the panel is scanning. A starvation guard guarantees bounded write latency. During blanking, writes win.

## Interface
- `ADDR_BITS`, 14: SPRAM word address width.
- `DATA_BITS`, 16: SPRAM word width (RGB565 pixel).
- `STARVE_LIMIT`, 8: number of consecutive denied write cycles before a write is forced; legal range 1..255.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `display_active`  in  1  high while the panel region is being scanned; selects the priority mode.
- `rd_valid`  in  1  display fetch requests a read.
- `rd_addr`  in  ADDR_BITS  read address.
- `rd_ready`  out  1  read accepted this cycle (combinational).
- `rd_data`  out  DATA_BITS  read data; equals `mem_rdata`, meaningful only when `rd_data_valid` is high.
- `rd_data_valid`  out  1  `rd_data` holds the result of the read accepted two cycles earlier.
- `wr_valid`  in  1  write requester has a word pending.
- `wr_addr`  in  ADDR_BITS  write address.
- `wr_data`  in  DATA_BITS  write data.
- `wr_ready`  out  1  write accepted this cycle (combinational).
- `mem_addr`  out  ADDR_BITS  registered SPRAM address.
- `mem_wdata`  out  DATA_BITS  registered SPRAM write data.
- `mem_we`  out  1  registered SPRAM write enable.
- `mem_rdata`  in  DATA_BITS  SPRAM read data, valid one cycle after the address is presented.
- `starve_events`  out  8  count of forced writes; wraps at 256.

## Operation
- Handshake: a transfer occurs in a cycle when valid and ready are both high. Requesters must not make valid depend on ready. Once valid is raised, address and data are held until the transfer.
- Grant logic is combinational from the inputs and the registered `wait_cnt`. At most one of `rd_ready`/`wr_ready` is high.
  - `display_active`=1, `wait_cnt` < `STARVE_LIMIT`: read priority. `rd_ready` = `rd_valid`; `wr_ready` = `wr_valid` & !`rd_valid`.
  - `display_active`=1, `wait_cnt` == `STARVE_LIMIT`, `wr_valid`=1: forced write. `wr_ready`=1, `rd_ready`=0, and `starve_events` increments.
  - `display_active`=0: write priority. `wr_ready` = `wr_valid`; `rd_ready` = `rd_valid` & !`wr_valid`.
- `wait_cnt` (width clog2(`STARVE_LIMIT`+1)) behaviour:
  - increments in any cycle with `wr_valid`=1 and `wr_ready`=0;
  - clears on a write transfer, or whenever `wr_valid`=0;
  - never exceeds `STARVE_LIMIT`.
- On a write transfer, at the clock edge: `mem_addr`<=`wr_addr`, `mem_wdata`<=`wr_data`, `mem_we`<=1.
- On a read transfer: `mem_addr`<=`rd_addr`, `mem_we`<=0. `mem_wdata` holds its value.
- On an idle cycle (no transfer): `mem_we`<=0, and `mem_addr`/`mem_wdata` hold their values.
- Read return: a 2-stage shift of the read-transfer flag drives `rd_data_valid`. `rd_data` is a direct wire from `mem_rdata`.

## Timing
- Reset values, asserted when `reset` is sampled high: `mem_addr`=0, `mem_wdata`=0, `mem_we`=0, `rd_data_valid`=0, `starve_events`=0, `wait_cnt`=0.
- Combinational `rd_ready`/`wr_ready` are 0 while `reset`=1.
- Reset mid-operation clears the read pipeline. A read accepted one cycle before reset must not produce `rd_data_valid`.
- Read latency: a transfer in cycle N gives `mem_addr` valid in N+1 and `rd_data_valid`=1 with data in N+2. Back-to-back reads sustain 1 word/cycle.
- Write: a transfer in cycle N gives `mem_we`=1 for exactly cycle N+1 per accepted word. Back-to-back writes sustain 1 word/cycle.
- Write latency bound while `display_active`=1 with continuous reads: the write is granted no later than the (`STARVE_LIMIT`+1)th cycle of `wr_valid`.
- A `display_active` change takes effect in the same cycle; it is combinational into the grant.
- Simultaneous `rd_valid` and `wr_valid` with `display_active`=0: the write wins, and `wait_cnt` stays 0.

## Test plan
- After reset, `display_active`=1, `rd_valid` held with addresses 0x0000..0x0009, `mem_rdata`=addr^0xA5A5 model: `rd_data_valid` is high cycles 2..11 after the first transfer, with data 0xA5A5, 0xA5A4, …. `mem_we` stays 0 throughout.
- `display_active`=1, continuous reads, `wr_valid`=1 `wr_addr`=0x0123 `wr_data`=0xF800 raised at cycle 0:
  - `wr_ready` is 0 for cycles 0..7 and 1 at cycle 8, with `rd_ready`=0 that cycle;
  - `mem_we`=1 with `mem_addr`=0x0123 and `mem_wdata`=0xF800 at cycle 9;
  - `starve_events`=1.
- `display_active`=0, `rd_valid`=`wr_valid`=1 for 3 writes (addresses 0x10..0x12): 3 consecutive `mem_we` pulses, no read granted until `wr_valid` falls, then the read completes 2 cycles later.
- Starvation clear: `wr_valid` high for 5 denied cycles, dropped for 1 cycle, then raised again under continuous reads: the write is granted 9 cycles after re-assertion (counter restarted), not 4.
- Reset mid-flight: read accepted at cycle N, `reset`=1 at N+1: `rd_data_valid` stays 0 through N+3, and all outputs hold their reset values.
- `starve_events` wrap: 256 forced writes return the counter to 0.
